// File: rtl/decoder_pkg.sv
// Shared types for the sequential N-to-2^N decoder: request modes and FSM states.
// No logic here. No latency or backpressure of its own.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'b00,
        MODE_THERM   = 2'b01,
        MODE_SWEEP   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/decode_core.sv
// Combinational one-hot and thermometer decode of a select code.
// Latency 0. No backpressure; pure function of sel.
module decode_core #(
    parameter  int IN_W  = 3,
    localparam int OUT_W = 2**IN_W
) (
    input  logic [IN_W-1:0]  sel,
    output logic [OUT_W-1:0] onehot,
    output logic [OUT_W-1:0] therm
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
        for (int i = 0; i < OUT_W; i++) begin
            therm[i] = (i <= int'(sel));
        end
    end

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered decoder: one-hot / thermometer single beats, or a 1<<k sweep of sel+1 beats.
// Latency 1 from acceptance. Holds the output beat while out_ready is low; no input accepted during a sweep.
module decoder_nx2n_seq
    import decoder_pkg::*;
#(
    parameter  int IN_W  = 3,
    localparam int OUT_W = 2**IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_sel,
    input  logic [1:0]       in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             err_mode
);

    state_e           state_q, state_d;
    logic [OUT_W-1:0] data_q,  data_d;
    logic             vld_q,   vld_d;
    logic             last_q,  last_d;
    logic             err_q,   err_d;
    logic [IN_W-1:0]  cnt_q,   cnt_d;
    logic [IN_W-1:0]  lim_q,   lim_d;

    logic             accept;
    logic             consume;
    logic [IN_W-1:0]  cnt_nxt;
    logic [IN_W-1:0]  core_sel;
    logic [OUT_W-1:0] dec_onehot;
    logic [OUT_W-1:0] dec_therm;
    mode_e            mode;

    assign mode     = mode_e'(in_mode);
    assign in_ready = (state_q == ST_IDLE) && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = vld_q && out_ready;
    assign cnt_nxt  = cnt_q + IN_W'(1);

    // The core is shared: it decodes the next sweep beat while sweeping, else the request.
    assign core_sel = (state_q == ST_SWEEP) ? cnt_nxt : in_sel;

    decode_core #(.IN_W(IN_W)) u_core (
        .sel    (core_sel),
        .onehot (dec_onehot),
        .therm  (dec_therm)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        vld_d   = vld_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        err_d   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                vld_d  = 1'b1;
                last_d = 1'b1;
                cnt_d  = '0;
                case (mode)
                    MODE_ONEHOT:  data_d = dec_onehot;
                    MODE_THERM:   data_d = dec_therm;
                    MODE_ILLEGAL: begin
                        data_d = dec_onehot;
                        err_d  = 1'b1;
                    end
                    MODE_SWEEP: begin
                        data_d = OUT_W'(1);
                        last_d = (in_sel == '0);
                        lim_d  = in_sel;
                        if (in_sel != '0) begin
                            state_d = ST_SWEEP;
                        end
                    end
                    default:      data_d = dec_onehot;
                endcase
            end else if (consume) begin
                vld_d  = 1'b0;
                last_d = 1'b0;
                data_d = '0;
            end
        end else if (consume) begin
            if (cnt_q == lim_q) begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
                last_d  = 1'b0;
                data_d  = '0;
                cnt_d   = '0;
            end else begin
                cnt_d  = cnt_nxt;
                data_d = dec_onehot;
                last_d = (cnt_nxt == lim_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = vld_q;
    assign out_last  = last_q;
    assign err_mode  = err_q;
    assign busy      = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Bench for decoder_nx2n_seq (IN_W=3): vector table, directed multi-cycle sequences,
// and randomized traffic against a queue-of-expected-beats reference model.
module tb_decoder_nx2n_seq;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_sel;
    logic [1:0] in_mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       err_mode;

    int checks = 0;
    int errors = 0;

    decoder_nx2n_seq #(.IN_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sel    (in_sel),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .err_mode  (err_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [1:0] mode;
        logic [7:0] data;
        logic       err;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       m;   // beat belongs to a multi-beat sweep
    } beat_t;

    vec_t  vecs [8];
    beat_t q [$];
    beat_t b;
    logic  exp_err;
    logic  exp_rdy;
    logic  acc, con;
    logic [1:0] md;
    logic [2:0] sl;
    int    seen_vld;

    initial begin
        rst_n     = 1'b0;
        in_sel    = '0;
        in_mode   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{sel: 3'd5, mode: 2'b00, data: 8'b0010_0000, err: 1'b0};
        vecs[1] = '{sel: 3'd3, mode: 2'b01, data: 8'b0000_1111, err: 1'b0};
        vecs[2] = '{sel: 3'd7, mode: 2'b01, data: 8'hFF,        err: 1'b0};
        vecs[3] = '{sel: 3'd0, mode: 2'b00, data: 8'h01,        err: 1'b0};
        vecs[4] = '{sel: 3'd7, mode: 2'b00, data: 8'h80,        err: 1'b0};
        vecs[5] = '{sel: 3'd0, mode: 2'b01, data: 8'h01,        err: 1'b0};
        vecs[6] = '{sel: 3'd2, mode: 2'b11, data: 8'h04,        err: 1'b1};
        vecs[7] = '{sel: 3'd0, mode: 2'b10, data: 8'h01,        err: 1'b0};

        // Reset state
        #3;
        chk("rst_data",  out_data,  0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last",  out_last,  0);
        chk("rst_busy",  busy,      0);
        chk("rst_err",   err_mode,  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_in_ready", in_ready, 1);

        // Single-beat vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_sel    = vecs[i].sel;
            in_mode   = vecs[i].mode;
            out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_data", i),  out_data,  vecs[i].data);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_last", i),  out_last,  1);
            chk($sformatf("vec%0d_err", i),   err_mode,  vecs[i].err);
            chk($sformatf("vec%0d_busy", i),  busy,      0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_clear_valid", i), out_valid, 0);
            chk($sformatf("vec%0d_clear_data", i),  out_data,  0);
            chk($sformatf("vec%0d_err_gone", i),    err_mode,  0);
        end

        // Sweep sel=3 with a 3-cycle stall on the second beat
        @(negedge clk);
        in_valid = 1'b1; in_sel = 3'd3; in_mode = 2'b10; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sel = 3'd6; in_mode = 2'b00;
        chk("sw_b0_data", out_data, 8'h01);
        chk("sw_b0_last", out_last, 0);
        chk("sw_b0_busy", busy, 1);
        chk("sw_b0_rdy",  in_ready, 0);
        @(posedge clk); #1;
        chk("sw_b1_data", out_data, 8'h02);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk($sformatf("sw_stall%0d_data", s), out_data, 8'h02);
            chk($sformatf("sw_stall%0d_last", s), out_last, 0);
            chk($sformatf("sw_stall%0d_rdy", s),  in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("sw_b2_data", out_data, 8'h04);
        chk("sw_b2_last", out_last, 0);
        chk("sw_b2_rdy",  in_ready, 0);
        @(posedge clk); #1;
        chk("sw_b3_data", out_data, 8'h08);
        chk("sw_b3_last", out_last, 1);
        chk("sw_b3_busy", busy, 1);
        chk("sw_b3_rdy",  in_ready, 0);
        @(posedge clk); #1;
        chk("sw_end_valid", out_valid, 0);
        chk("sw_end_busy",  busy, 0);
        chk("sw_end_data",  out_data, 0);
        chk("sw_end_rdy",   in_ready, 1);

        // Back-to-back one-hot 0,1,2 then illegal mode with sel=2
        @(negedge clk);
        in_valid = 1'b1; in_sel = 3'd0; in_mode = 2'b00; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("b2b_0", out_data, 8'h01);
        chk("b2b_rdy0", in_ready, 1);
        in_sel = 3'd1;
        @(posedge clk); #1;
        chk("b2b_1", out_data, 8'h02);
        chk("b2b_v1", out_valid, 1);
        in_sel = 3'd2;
        @(posedge clk); #1;
        chk("b2b_2", out_data, 8'h04);
        chk("b2b_v2", out_valid, 1);
        chk("b2b_noerr", err_mode, 0);
        in_mode = 2'b11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ill_data", out_data, 8'h04);
        chk("ill_err",  err_mode, 1);
        @(posedge clk); #1;
        chk("ill_err_pulse", err_mode, 0);
        chk("ill_drained", out_valid, 0);

        // Reset in the middle of a sweep sel=7
        @(negedge clk);
        in_valid = 1'b1; in_sel = 3'd7; in_mode = 2'b10; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rs_b0", out_data, 8'h01);
        @(posedge clk); #1;
        chk("rs_b1", out_data, 8'h02);
        @(posedge clk); #1;
        chk("rs_b2", out_data, 8'h04);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_data",  out_data,  0);
        chk("rs_valid", out_valid, 0);
        chk("rs_last",  out_last,  0);
        chk("rs_busy",  busy,      0);
        chk("rs_err",   err_mode,  0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_vld = 0;
        @(posedge clk); #1;
        chk("rs_release_rdy", in_ready, 1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen_vld++;
        end
        chk("rs_no_beats_after", seen_vld, 0);

        // Randomized traffic against the beat-queue model
        exp_err = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_sel    = 3'($urandom_range(0, 7));
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_rdy = (q.size() == 0) || (q.size() == 1 && !q[0].m && out_ready);
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("rnd_data", out_data, q[0].d);
                chk("rnd_last", out_last, q[0].l);
                chk("rnd_busy", busy, q[0].m);
            end else begin
                chk("rnd_idle_data", out_data, 0);
                chk("rnd_idle_busy", busy, 0);
            end
            chk("rnd_err", err_mode, exp_err);
            acc = in_valid && exp_rdy;
            con = (q.size() != 0) && out_ready;
            md  = in_mode;
            sl  = in_sel;
            @(posedge clk);
            if (con) void'(q.pop_front());
            exp_err = acc && (md == 2'b11);
            if (acc) begin
                if (md == 2'b10) begin
                    for (int k = 0; k <= int'(sl); k++) begin
                        b.d = 8'd1 << k;
                        b.l = (k == int'(sl));
                        b.m = (sl != 3'd0);
                        q.push_back(b);
                    end
                end else begin
                    b.d = (md == 2'b01) ? 8'((2 << sl) - 1) : (8'd1 << sl);
                    b.l = 1'b1;
                    b.m = 1'b0;
                    q.push_back(b);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_nx2n_seq.md
DECODER_NX2N_SEQ -- requirements
Module: decoder_nx2n_seq

Interface
REQ-001 The block SHALL have parameter IN_W, default 3, meaning the select width (legal range 1..6).
REQ-002 The block SHALL derive localparam OUT_W = 2**IN_W, default 8, meaning the decoded output width.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port in_sel  input  IN_W  meaning the select code.
REQ-006 The block SHALL have port in_mode  input  2  meaning the request mode: 00 one-hot, 01 thermometer, 10 sweep, 11 illegal.
REQ-007 The block SHALL have port in_valid  input  1  meaning the request is valid.
REQ-008 The block SHALL have port in_ready  output  1  meaning the block accepts a request this cycle.
REQ-009 The block SHALL have port out_data  output  OUT_W  meaning the decoded word.
REQ-010 The block SHALL have port out_valid  output  1  meaning out_data is valid.
REQ-011 The block SHALL have port out_ready  input  1  meaning the consumer accepts out_data.
REQ-012 The block SHALL have port out_last  output  1  meaning this beat is the final beat of the request.
REQ-013 The block SHALL have port busy  output  1  meaning a sweep is in progress.
REQ-014 The block SHALL have port err_mode  output  1  meaning a one-cycle pulse when an illegal mode is accepted.

Function
REQ-015 A request SHALL be accepted on a cycle where in_valid and in_ready are both 1; a beat SHALL be consumed on a cycle where out_valid and out_ready are both 1.
REQ-016 In state IDLE, in_ready SHALL equal (!out_valid || out_ready); in state SWEEP, in_ready SHALL be 0.
REQ-017 One-hot mode SHALL register out_data = 1 << in_sel, with out_last=1 and out_valid=1, one cycle after acceptance (latency 1).
REQ-018 Thermometer mode SHALL register out_data bits 0..in_sel set and all higher bits clear, with out_last=1 and latency 1.
REQ-019 Illegal mode 11 SHALL be decoded as one-hot and SHALL pulse err_mode for exactly the cycle after acceptance.
REQ-020 Sweep mode SHALL capture in_sel as a limit and emit in_sel+1 beats: out_data = 1<<k for k = 0..in_sel in order, with out_last=1 only on beat k = in_sel.
REQ-021 The FSM SHALL have two states: IDLE -> SWEEP on acceptance of a sweep request with in_sel > 0; SWEEP -> IDLE when the last beat is consumed.
REQ-022 A sweep with in_sel=0 SHALL produce a single beat (out_data=1, out_last=1) and the FSM SHALL remain in IDLE.
REQ-023 busy SHALL be 1 exactly while the state is SWEEP.
REQ-024 The sweep counter SHALL be IN_W bits wide and SHALL advance only when a beat is consumed.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_last and the counter SHALL hold stable.
REQ-026 A beat consumed in IDLE in the same cycle as a new request is accepted SHALL be replaced by the new result in the next cycle with no bubble.
REQ-027 If out_valid=0 after a beat is consumed with no new acceptance, out_data SHALL be cleared to 0.
REQ-028 The mode and select SHALL be sampled only at acceptance; changes to in_mode or in_sel during SWEEP SHALL be ignored.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately and asynchronously force out_data=0, out_valid=0, out_last=0, busy=0, err_mode=0, counter=0 and state IDLE.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; no further beats SHALL be emitted after release.
REQ-031 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-032 A shared package decoder_pkg SHALL hold the mode enum (MODE_ONEHOT, MODE_THERM, MODE_SWEEP, MODE_ILLEGAL) and the FSM state enum.
REQ-033 The combinational one-hot/thermometer decode SHALL be a sub-module decode_core (parameter IN_W), instantiated once.

Verification
REQ-034 One-hot: IN_W=3, in_sel=5, mode 00, out_ready=1 -> next cycle out_data=8'b0010_0000, out_last=1.
REQ-035 Thermometer: in_sel=3, mode 01 -> out_data=8'b0000_1111, out_last=1; in_sel=7 -> 8'hFF.
REQ-036 Sweep with stall: in_sel=3, mode 10, out_ready low on the 2nd beat for 3 cycles -> beats 01,02,04,08 in order, 02 held during the stall, last only on 08, in_ready=0 throughout.
REQ-037 Back-to-back: one-hot requests 0,1,2 on consecutive cycles with out_ready=1 -> out_data 01,02,04 on consecutive cycles with no gaps; mode 11 with in_sel=2 -> 04 and one err_mode pulse.
REQ-038 Reset mid-sweep: sweep in_sel=7, rst_n low after beat 3 -> all outputs 0 immediately, busy=0, no beats after release, in_ready=1.
